// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves control-flow instructions at the EX/MEM boundary. For each captured conditional
// branch, JAL or JALR it computes the actual direction and target, classifies the instruction
// as call and/or return, and compares the result against the prediction carried down from IF.
// One cycle after capture it emits a single-cycle predictor update (branch_*). On a
// mispredict it also emits a coincident front-end redirect (redirect_*). After every redirect
// a wrong-path shadow window of SHADOW_CYCLES non-stalled cycles ignores ex_valid_i, so
// wrong-path instructions never update the predictor.
//
// Optional feature macro: BRU_PERF_COUNTERS_EN
//   defined   -> perf_branches_o / perf_mispredicts_o are live 32-bit wrapping counters
//   undefined -> no counter flops; both ports are tied to 0
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ex_valid_i            EX holds a live instruction
//   ex_pc_i               instruction PC
//   ex_opcode_i/funct3_i  instruction decode fields
//   ex_rd_i, ex_rs1_i     register indices, used for call/return classification
//   ex_imm_i              sign-extended immediate
//   ex_rs1_val_i/rs2_val  forwarded operands
//   ex_pred_taken_i       IF-stage predicted direction
//   ex_pred_target_i      IF-stage predicted target
//   stall_i               pipeline hold: no capture, shadow count frozen
//   flush_i               external flush: no capture, FSM forced back to RUN
//   redirect_valid_o/pc_o one-cycle fetch redirect
//   branch_*_o            one-cycle registered predictor update
//   perf_*_o              optional performance counters
// ---------------------------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic [ADDR_WIDTH-1:0] ex_pc_i,
    input  logic [6:0]            ex_opcode_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [4:0]            ex_rd_i,
    input  logic [4:0]            ex_rs1_i,
    input  logic [31:0]           ex_imm_i,
    input  logic [31:0]           ex_rs1_val_i,
    input  logic [31:0]           ex_rs2_val_i,
    input  logic                  ex_pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  redirect_valid_o,
    output logic [ADDR_WIDTH-1:0] redirect_pc_o,
    output logic                  branch_valid_o,
    output logic [ADDR_WIDTH-1:0] branch_pc_o,
    output logic                  branch_taken_o,
    output logic [ADDR_WIDTH-1:0] branch_target_o,
    output logic                  branch_is_cond_o,
    output logic                  branch_is_call_o,
    output logic                  branch_is_return_o,
    output logic                  branch_mispredict_o,
    output logic [31:0]           perf_branches_o,
    output logic [31:0]           perf_mispredicts_o
);

    localparam int unsigned CntW = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [0:0] {StRun, StShadow} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] shadow_cnt_q, shadow_cnt_d;

    // ------------------------------------------------------------------------------------------
    // Decode and resolve
    // ------------------------------------------------------------------------------------------
    logic                  is_branch, is_jal, is_jalr, is_cf;
    logic                  cond_taken;
    logic [ADDR_WIDTH-1:0] imm_ext, rs1_ext, pc_plus_imm, jalr_sum;
    logic                  taken_d, is_call_d, is_return_d, mispredict_d;
    logic [ADDR_WIDTH-1:0] target_d, redirect_pc_d;
    logic                  capture;

    always_comb begin
        is_jal    = (ex_opcode_i == OpJal);
        is_jalr   = (ex_opcode_i == OpJalr);
        // funct3 010/011 under the branch opcode are not control flow
        is_branch = (ex_opcode_i == OpBranch) &&
                    (ex_funct3_i != 3'b010) && (ex_funct3_i != 3'b011);
        is_cf     = is_branch | is_jal | is_jalr;

        cond_taken = 1'b0;
        case (ex_funct3_i)
            3'b000:  cond_taken = (ex_rs1_val_i == ex_rs2_val_i);
            3'b001:  cond_taken = (ex_rs1_val_i != ex_rs2_val_i);
            3'b100:  cond_taken = ($signed(ex_rs1_val_i) <  $signed(ex_rs2_val_i));
            3'b101:  cond_taken = ($signed(ex_rs1_val_i) >= $signed(ex_rs2_val_i));
            3'b110:  cond_taken = (ex_rs1_val_i <  ex_rs2_val_i);
            3'b111:  cond_taken = (ex_rs1_val_i >= ex_rs2_val_i);
            default: cond_taken = 1'b0;
        endcase

        // Immediate is sign-extended (or truncated) to the PC width; sums wrap modulo 2^W
        imm_ext     = ADDR_WIDTH'($signed(ex_imm_i));
        rs1_ext     = ADDR_WIDTH'(ex_rs1_val_i);
        pc_plus_imm = ex_pc_i + imm_ext;
        jalr_sum    = rs1_ext + imm_ext;

        taken_d  = is_branch ? cond_taken : 1'b1;
        target_d = is_jalr ? {jalr_sum[ADDR_WIDTH-1:1], 1'b0} : pc_plus_imm;

        is_call_d   = (is_jal | is_jalr) && ((ex_rd_i == 5'd1) || (ex_rd_i == 5'd5));
        is_return_d = is_jalr && (ex_rs1_i == 5'd1) && (ex_rd_i == 5'd0);

        // Predicted target only matters when the branch is actually taken
        mispredict_d  = (taken_d != ex_pred_taken_i) |
                        (taken_d & (ex_pred_target_i != target_d));
        redirect_pc_d = taken_d ? target_d : ex_pc_i + ADDR_WIDTH'(4);

        capture = ex_valid_i & is_cf & ~stall_i & ~flush_i & (state_q == StRun);
    end

    // ------------------------------------------------------------------------------------------
    // Wrong-path shadow FSM
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        if (flush_i) begin
            state_d      = StRun;
            shadow_cnt_d = '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (capture && mispredict_d && (SHADOW_CYCLES != 0)) begin
                        state_d      = StShadow;
                        shadow_cnt_d = CntW'(SHADOW_CYCLES);
                    end
                end
                StShadow: begin
                    if (!stall_i) begin
                        if (shadow_cnt_q <= CntW'(1)) begin
                            state_d      = StRun;
                            shadow_cnt_d = '0;
                        end else begin
                            shadow_cnt_d = shadow_cnt_q - CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d      = StRun;
                    shadow_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            shadow_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Registered update / redirect. Valid bits follow capture every cycle so they can never
    // stretch; payload fields only load on capture.
    // ------------------------------------------------------------------------------------------
    logic                  branch_valid_q, redirect_valid_q;
    logic [ADDR_WIDTH-1:0] branch_pc_q, branch_target_q, redirect_pc_q;
    logic                  taken_q, is_cond_q, is_call_q, is_return_q, mispredict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_valid_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            branch_pc_q      <= '0;
            branch_target_q  <= '0;
            redirect_pc_q    <= '0;
            taken_q          <= 1'b0;
            is_cond_q        <= 1'b0;
            is_call_q        <= 1'b0;
            is_return_q      <= 1'b0;
            mispredict_q     <= 1'b0;
        end else begin
            branch_valid_q   <= capture;
            redirect_valid_q <= capture & mispredict_d;
            if (capture) begin
                branch_pc_q     <= ex_pc_i;
                branch_target_q <= target_d;
                redirect_pc_q   <= redirect_pc_d;
                taken_q         <= taken_d;
                is_cond_q       <= is_branch;
                is_call_q       <= is_call_d;
                is_return_q     <= is_return_d;
                mispredict_q    <= mispredict_d;
            end
        end
    end

    assign branch_valid_o      = branch_valid_q;
    assign branch_pc_o         = branch_pc_q;
    assign branch_taken_o      = taken_q;
    assign branch_target_o     = branch_target_q;
    assign branch_is_cond_o    = is_cond_q;
    assign branch_is_call_o    = is_call_q;
    assign branch_is_return_o  = is_return_q;
    assign branch_mispredict_o = mispredict_q;
    assign redirect_valid_o    = redirect_valid_q;
    assign redirect_pc_o       = redirect_pc_q;

    // ------------------------------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------------------------------
`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] perf_branches_q, perf_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else if (branch_valid_q) begin
            perf_branches_q <= perf_branches_q + 32'd1;
            if (mispredict_q) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches_o    = perf_branches_q;
    assign perf_mispredicts_o = perf_mispredicts_q;
`else
    assign perf_branches_o    = '0;
    assign perf_mispredicts_o = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits at the EX/MEM boundary and resolves control-flow instructions: comparison outcome, actual target, call/return class, and mispredict against the prediction carried down the pipeline.
- Produces the registered one-cycle branch-outcome update consumed by the advanced branch predictor, plus the front-end redirect/flush request.
- Tracks a wrong-path shadow window after each redirect so that in-flight wrong-path instructions never generate updates.

Parameters:
- ADDR_WIDTH, 32, PC/target width.
- SHADOW_CYCLES, 2, number of non-stalled cycles after a redirect during which ex_valid is ignored.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ex_valid  input  1  EX holds a live instruction
- ex_pc  input  ADDR_WIDTH  instruction PC
- ex_opcode  input  7  opcode
- ex_funct3  input  3  funct3
- ex_rd  input  5  destination register
- ex_rs1  input  5  source register 1 index
- ex_imm  input  32  sign-extended immediate (B/J/I form)
- ex_rs1_val  input  32  forwarded rs1 value
- ex_rs2_val  input  32  forwarded rs2 value
- ex_pred_taken  input  1  IF-stage predicted direction
- ex_pred_target  input  ADDR_WIDTH  IF-stage predicted target
- stall  input  1  pipeline hold; no capture, shadow count frozen
- flush_in  input  1  external flush (trap/exception)
- redirect_valid  output  1  one-cycle pulse: front end must fetch redirect_pc
- redirect_pc  output  ADDR_WIDTH  corrected fetch PC
- branch_valid  output  1  one-cycle update pulse
- branch_pc  output  ADDR_WIDTH  PC of resolved instruction
- branch_taken  output  1  actual direction
- branch_target  output  ADDR_WIDTH  computed target (also for untaken conditional branches)
- branch_is_cond  output  1  conditional branch
- branch_is_call  output  1  JAL/JALR with rd in {x1, x5}
- branch_is_return  output  1  JALR with rs1 = x1 and rd = x0
- branch_mispredict  output  1  prediction was wrong
- perf_branches  output  32  resolved-branch count (optional feature)
- perf_mispredicts  output  32  mispredict count (optional feature)

Behaviour:
- Reset: all outputs 0, state RUN, shadow counter 0.
- Decode:
  - BRANCH 1100011: funct3 000/001/100/101/110/111 = BEQ/BNE/BLT/BGE/BLTU/BGEU, signed/unsigned compares as named. funct3 010/011 is not control flow; it produces no update.
  - JAL 1101111: target = pc + imm.
  - JALR 1100111: target = (rs1_val + imm) & ~1.
  - JAL and JALR are always taken.
- Target arithmetic: modulo 2^ADDR_WIDTH; wrap-around is allowed.
- Conditional branch target is pc + imm.
- Mispredict = (taken != pred_taken) | (taken & pred_target != target).
- Untaken, correctly predicted not-taken: pred_target is ignored.
- Capture condition: posedge with ex_valid & control-flow & !stall & !flush_in & state RUN.
- On capture, next cycle:
  - branch_valid = 1, with all branch_* fields registered.
  - If mispredict: redirect_valid = 1, redirect_pc = taken ? target : pc + 4.
- Latency: exactly 1 cycle from EX capture to update and redirect. Update and redirect are coincident.
- Pulses: branch_valid and redirect_valid are high for exactly one cycle, even if stall is asserted in the following cycle. A held instruction is never reported twice.
- State machine:
  - RUN: on capture with mispredict, go to SHADOW with counter = SHADOW_CYCLES.
  - SHADOW: ex_valid is ignored. Counter decrements on each !stall cycle; at 0, return to RUN.
  - With SHADOW_CYCLES = 0, the FSM stays in RUN.
- flush_in:
  - Suppresses capture that cycle.
  - Clears any update/redirect that would otherwise be registered that cycle.
  - Forces RUN with counter 0.
  - flush_in has priority over everything except reset.
- Simultaneous stall & flush_in: flush_in wins.
- Reset mid-operation: asynchronously clears pending pulses, state and counters.
- Back-to-back correct branches in consecutive RUN cycles produce consecutive branch_valid pulses.

Optional Feature:
- BRU_PERF_COUNTERS_EN defined:
  - perf_branches increments on every branch_valid pulse.
  - perf_mispredicts increments on every branch_valid & branch_mispredict.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- BRU_PERF_COUNTERS_EN undefined: no counter flops; both ports are tied to 0.

Test Plan:
- BEQ, pc = 0x100, imm = 0x20, rs1 = rs2 = 5, pred_taken = 1, pred_target = 0x120 -> next cycle: branch_valid = 1, taken = 1, target = 0x120, is_cond = 1, mispredict = 0, redirect_valid = 0, state stays RUN.
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x200, imm = 0x40, pred_taken = 0 -> taken = 1, mispredict = 1, redirect_pc = 0x240. The next 2 ex_valid branch cycles produce no branch_valid; the third does.
- BLTU, same operands, pred_taken = 1, pred_target = 0x240 -> taken = 0, mispredict = 1, redirect_pc = 0x204, branch_target = 0x240.
- JALR, rd = 0, rs1 = 1, rs1_val = 0x1235, imm = 0, pred_target = 0x1234 -> target = 0x1234, is_return = 1, mispredict = 0. Then JAL, rd = 1, pc = 0x300, imm = 0x100, pred_taken = 0 -> is_call = 1, redirect_pc = 0x400.
- Mispredicting branch captured, then stall held 3 cycles -> branch_valid high 1 cycle only, SHADOW count frozen during stall. Then flush_in with ex_valid branch -> no update, state RUN.
- With BRU_PERF_COUNTERS_EN: 5 branches including 2 mispredicts -> perf_branches = 5, perf_mispredicts = 2. Without the macro, both read 0.
